pixel_capture_writer: RTL

PIXEL_CAPTURE_WRITER -- requirements
Module: pixel_capture_writer

---
 rtl/capture_pkg.sv | 13 +
 rtl/byte_pair_packer.sv | 46 ++++
 rtl/pixel_capture_writer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared defaults and the FSM state type for the pixel capture writer.
package capture_pkg;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int DEF_ADDR_W     = 19;

    typedef enum logic [1:0] {
        S_idle,
        S_in_line,
        S_line_gap,
        S_done
    } state_t;
endpackage

// File: rtl/byte_pair_packer.sv
// Pairs consecutive camera bytes into 16-bit RGB565 words and tracks the byte phase.
module byte_pair_packer
    import capture_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sample,
    input  logic        restart,
    input  logic [7:0]  byte_in,
    output logic        phase,
    output logic        pair_valid,
    output logic [15:0] pair_data
);
    logic       phase_reg, phase_next;
    logic [7:0] held_reg, held_next;
    logic       eff_phase;

    // A line restart forces the incoming byte to be treated as the first of a pair.
    assign eff_phase  = restart ? 1'b0 : phase_reg;
    assign phase      = phase_reg;
    assign pair_valid = sample & eff_phase;
    assign pair_data  = {held_reg, byte_in};

    always_comb begin
        phase_next = phase_reg;
        held_next  = held_reg;
        if (sample) begin
            phase_next = ~eff_phase;
            if (!eff_phase) begin
                held_next = byte_in;
            end
        end else if (restart) begin
            phase_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_reg <= 1'b0;
            held_reg  <= 8'h00;
        end else begin
            phase_reg <= phase_next;
            held_reg  <= held_next;
        end
    end
endmodule

// File: rtl/pixel_capture_writer.sv
// Captures one camera frame as RGB565 pixels and writes them into a linear frame buffer.
module pixel_capture_writer
    import capture_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              VS,
    input  logic [7:0]        pixel_byte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);
    localparam int COL_W  = $clog2(IMG_WIDTH + 1);
    localparam int LINE_W = $clog2(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_WIDTH);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(IMG_HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_WIDTH);

    state_t              state_reg, state_next;
    logic                vs_old_reg;
    logic [COL_W-1:0]    col_reg;
    logic [LINE_W-1:0]   line_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   line_base_reg;
    logic                wr_en_reg, err_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [15:0]         wr_data_reg;

    logic        vs_fall, frame_start, start_line, take_byte, line_end;
    logic        in_range, write_ok;
    logic        phase, pair_valid;
    logic [15:0] pair_data;

    assign vs_fall     = vs_old_reg & ~VS;
    assign frame_start = (state_reg == S_idle) && capture;
    // Frame end wins over a capture rise arriving in the same gap cycle.
    assign start_line  = frame_start || ((state_reg == S_line_gap) && capture && !vs_fall);
    assign take_byte   = start_line || ((state_reg == S_in_line) && capture && !vs_fall);
    assign line_end    = (state_reg == S_in_line) && (!capture || vs_fall);
    assign in_range    = (col_reg < COL_MAX) && (line_reg < LINE_MAX);
    assign write_ok    = pair_valid && in_range;

    byte_pair_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .sample     (take_byte),
        .restart    (start_line),
        .byte_in    (pixel_byte),
        .phase      (phase),
        .pair_valid (pair_valid),
        .pair_data  (pair_data)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_idle:     if (capture) state_next = S_in_line;
            S_in_line:  if (vs_fall) state_next = S_done;
                        else if (!capture) state_next = S_line_gap;
            S_line_gap: if (vs_fall) state_next = S_done;
                        else if (capture) state_next = S_in_line;
            S_done:     state_next = S_idle;
            default:    state_next = S_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_idle;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_old_reg    <= 1'b0;
            col_reg       <= '0;
            line_reg      <= '0;
            addr_reg      <= '0;
            line_base_reg <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= 16'h0000;
            err_reg       <= 1'b0;
        end else begin
            vs_old_reg <= VS;
            wr_en_reg  <= write_ok;
            if (write_ok) begin
                wr_addr_reg <= addr_reg;
                wr_data_reg <= pair_data;
                addr_reg    <= addr_reg + ADDR_W'(1);
            end
            // Column saturates at the width so overflow stays detectable.
            if (pair_valid && col_reg != COL_MAX) begin
                col_reg <= col_reg + COL_W'(1);
            end
            if (line_end) begin
                col_reg <= '0;
                if (line_reg != LINE_MAX) begin
                    line_reg      <= line_reg + LINE_W'(1);
                    line_base_reg <= line_base_reg + LINE_STEP;
                    addr_reg      <= line_base_reg + LINE_STEP;
                end
            end
            if (state_reg == S_done) begin
                col_reg       <= '0;
                line_reg      <= '0;
                addr_reg      <= '0;
                line_base_reg <= '0;
            end
            if (frame_start) begin
                err_reg <= 1'b0;
            end else if ((line_end && phase) || (pair_valid && !in_range)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign err        = err_reg;
    assign frame_done = (state_reg == S_done);
    assign busy       = (state_reg == S_in_line) || (state_reg == S_line_gap);
endmodule
